fetch_pc: RTL

Program-counter and next-PC stage of the single-cycle MIPS datapath. It sits directly upstream of the instruction memory and drives its 10-bit word address from the current PC. Each cycle it computes the next PC (sequential, branch, jump, or jump-register). It holds the PC on stall and freezes the machine in a HALT state when a syscall is fetched. It also keeps a retired-instruction counter for the bench and for debug.

---
 rtl/fetch_pc.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_pc.sv
// Program counter / next-PC stage: sequential, branch, jump and jr targets,
// stall hold, syscall HALT and a saturating retired-instruction counter.
// Optional misaligned-jr trap when FETCH_ALIGN_CHECK_EN is defined.
module fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       npc_sel,
    input  logic             branch_taken,
    input  logic [15:0]      imm16,
    input  logic [25:0]      target26,
    input  logic [31:0]      jr_addr,
    input  logic [31:0]      instr_in,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [IM_AW-1:0] im_addr,
    output logic             halted,
    output logic [31:0]      instr_count,
    output logic             misalign
);

    localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;
    localparam logic [31:0] COUNT_MAX     = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_plus4_s;
    logic [31:0] br_off_s;
    logic [31:0] npc_s;
    logic [31:0] cnt_inc_s;
    logic        is_syscall_s;
    logic        jr_bad_s;

    // next-PC source selection
    always_comb begin
        pc_plus4_s = pc_q + 32'd4;
        br_off_s   = {{14{imm16[15]}}, imm16, 2'b00};
        case (npc_sel)
            2'b00: npc_s = pc_plus4_s;
            2'b01: begin
                if (branch_taken) begin
                    npc_s = pc_plus4_s + br_off_s;
                end else begin
                    npc_s = pc_plus4_s;
                end
            end
            2'b10: npc_s = {pc_plus4_s[31:28], target26, 2'b00};
            2'b11: npc_s = {jr_addr[31:2], 2'b00};
            default: npc_s = pc_plus4_s;
        endcase
    end

    assign cnt_inc_s    = (cnt_q == COUNT_MAX) ? COUNT_MAX : (cnt_q + 32'd1);
    assign is_syscall_s = (instr_in == SYSCALL_INSTR);

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign jr_bad_s = (npc_sel == 2'b11) && (jr_addr[1:0] != 2'b00);

    // misalign flag sets only on the trap edge and then holds until reset
    always_comb begin
        misalign_d = misalign_q;
        if ((state_q == ST_RUN) && !stall && !is_syscall_s && jr_bad_s) begin
            misalign_d = 1'b1;
        end else begin
            misalign_d = misalign_q;
        end
    end

    // misalign flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_jr_low_s;

    assign jr_bad_s        = 1'b0;
    assign unused_jr_low_s = ^jr_addr[1:0];
    assign misalign        = 1'b0;
`endif

    // RUN/HALT next-state, PC and counter update; syscall wins over the jr trap
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    state_d = ST_RUN;
                end else if (is_syscall_s) begin
                    state_d = ST_HALT;
                    cnt_d   = cnt_inc_s;
                end else if (jr_bad_s) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d  = npc_s;
                    cnt_d = cnt_inc_s;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // architectural state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign im_addr     = pc_q[IM_AW+1:2];
    assign halted      = (state_q == ST_HALT);
    assign instr_count = cnt_q;

endmodule
